// File: rtl/divide_by_n_5.sv
// divide_by_n_5: run-time programmable fractional clock divider.
// clockout has a period of H half-cycles of clockin. It is high for ceil(H/2)
// half-cycles and low for floor(H/2). A posedge counter walks a double period
// (H full clockin cycles, i.e. two output periods). The output is the OR of
// one posedge-registered term and one negedge-registered term.
module divide_by_n_5 #(
  parameter int WIDTH            = 4,
  parameter int DEFAULT_HALF_DIV = 3
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] half_div,
  input  logic             div_load,
  output logic             clockout,
  output logic             div_pending,
  output logic [WIDTH-1:0] half_div_active
);

  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_HALF_DIV);
  localparam logic [WIDTH-1:0] MIN_H = WIDTH'(3);

  // Ideal output level in half-cycle t of a double period (t in 0..2H).
  function automatic logic level_at(input logic [WIDTH:0] t, input logic [WIDTH-1:0] h);
    logic [WIDTH:0] hx;
    logic [WIDTH:0] ph;
    logic [WIDTH:0] hi_len;
    hx     = {1'b0, h};
    ph     = (t >= hx) ? (t - hx) : t;
    hi_len = (hx + (WIDTH+1)'(1)) >> 1;
    return ph < hi_len;
  endfunction

  // A contributor registered at edge t stays up for half-cycles t and t+1,
  // so it may only be high when both are high. High runs are at least two
  // half-cycles long, so the OR of the two contributors reproduces the
  // ideal level. Each contributor changes only on its own edge, so the two
  // never move on the same edge and the output cannot glitch.
  function automatic logic hold_high(input logic [WIDTH:0] t, input logic [WIDTH-1:0] h);
    return level_at(t, h) & level_at(t + (WIDTH+1)'(1), h);
  endfunction

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] h);
    return (h < MIN_H) ? MIN_H : h;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             stop_q, stop_d;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pval_q, pval_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             bnd;

  assign cnt_inc = cnt_q + WIDTH'(1);
  // Every idle posedge counts as a boundary, so a restart always begins a fresh double period.
  assign bnd     = !run_q || (cnt_q == (act_q - WIDTH'(1)));

  // Posedge next-state: counter, run/stop control, divisor hand-over, posedge contributor.
  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    stop_d = stop_q;
    pos_d  = 1'b0;
    act_d  = act_q;
    pend_d = pend_q;
    pval_d = pval_q;
    if (bnd) begin
      // The value pending before this edge governs it; a same-edge load waits.
      if (pend_q) begin
        act_d  = pval_q;
        pend_d = 1'b0;
      end
      stop_d = 1'b0;
      cnt_d  = '0;
      if (run_q && (stop_q || !en)) begin
        run_d = 1'b0;
      end else if (en) begin
        run_d = 1'b1;
        pos_d = 1'b1;
      end else begin
        run_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc;
      pos_d = hold_high({cnt_inc, 1'b0}, act_q);
      // A low en seen anywhere inside the double period stops it at its end.
      if (!en) begin
        stop_d = 1'b1;
      end
    end
    if (div_load) begin
      pval_d = clamp_div(half_div);
      pend_d = 1'b1;
    end
  end

  // Posedge state register with synchronous reset.
  always_ff @(posedge clockin) begin
    if (reset) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      stop_q <= 1'b0;
      pos_q  <= 1'b0;
      act_q  <= DEF_H;
      pend_q <= 1'b0;
      pval_q <= DEF_H;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      stop_q <= stop_d;
      pos_q  <= pos_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pval_q <= pval_d;
    end
  end

  // Negedge contributor covers the odd half-cycle of the current posedge cycle.
  always_comb begin
    neg_d = run_q & hold_high({cnt_q, 1'b1}, act_q);
  end

  // Negedge shadow register, reset synchronously on its own edge.
  always_ff @(negedge clockin) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign clockout        = pos_q | neg_q;
  assign div_pending     = pend_q;
  assign half_div_active = act_q;

endmodule

// File: tb/tb_divide_by_n_5.sv
// Bench for divide_by_n_5: a half-cycle reference model checks every edge,
// table vectors measure period/high time, and hand sequences cover loads,
// enable drop and reset.
module tb_divide_by_n_5;

  logic       clockin = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] half_div = 4'd0;
  logic       div_load = 1'b0;
  logic       clockout;
  logic       div_pending;
  logic [3:0] half_div_active;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  divide_by_n_5 #(.WIDTH(4), .DEFAULT_HALF_DIV(3)) dut (
    .clockin(clockin),
    .reset(reset),
    .en(en),
    .half_div(half_div),
    .div_load(div_load),
    .clockout(clockout),
    .div_pending(div_pending),
    .half_div_active(half_div_active)
  );

  always #5 clockin = ~clockin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t is the half-cycle index inside the current double period.
  int m_t = 0;
  int m_h = 3;
  bit m_run = 0, m_stop = 0, m_pend = 0, m_lvl = 0, m_dc = 1;
  int m_pval = 3;

  function automatic bit lvl_of(int t, int h);
    return (t % h) < ((h + 1) / 2);
  endfunction

  always @(posedge clockin) begin
    if (reset) begin
      m_run = 0; m_stop = 0; m_h = 3; m_pend = 0; m_t = 0;
    end else begin
      if (m_run && (m_t + 1 < 2 * m_h)) begin
        m_t++;
        if (!en) m_stop = 1;
      end else begin
        if (m_pend) begin
          m_h = m_pval;
          m_pend = 0;
        end
        if (m_run && (m_stop || !en)) m_run = 0;
        else if (en) m_run = 1;
        m_stop = 0;
        m_t = 0;
      end
      if (div_load) begin
        m_pval = (half_div < 3) ? 3 : int'(half_div);
        m_pend = 1;
      end
    end
    m_lvl = m_run && lvl_of(m_t, m_h);
    m_dc = 0;
    #3;
    if (chk_en) begin
      if (!m_dc) chk("clockout_pos", clockout, m_lvl);
      chk("div_pending", div_pending, m_pend);
      chk("half_div_active", half_div_active, m_h);
    end
  end

  always @(negedge clockin) begin
    if (reset) begin
      m_dc = 1;
    end else if (m_run) begin
      m_t++;
      m_lvl = lvl_of(m_t, m_h);
    end
    #3;
    if (chk_en && !m_dc) chk("clockout_neg", clockout, m_lvl);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clockin);
    #1;
  endtask

  task automatic wait_lvl(input logic v, inout bit ok);
    for (int i = 0; i < 400; i++) begin
      if (clockout === v) return;
      #1;
    end
    ok = 0;
  endtask

  task automatic measure(output int per, output int hi, output bit ok);
    longint t0, t1, t2;
    ok = 1;
    wait_lvl(1'b0, ok);
    wait_lvl(1'b1, ok); t0 = $time;
    wait_lvl(1'b0, ok); t1 = $time;
    wait_lvl(1'b1, ok); t2 = $time;
    per = int'(t2 - t0);
    hi = int'(t1 - t0);
  endtask

  task automatic load(input logic [3:0] h);
    half_div = h;
    div_load = 1'b1;
    tick(1);
    div_load = 1'b0;
  endtask

  typedef struct {
    int h;
    int per;
    int hi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int per, hi;
    bit ok;
    vecs[0] = '{h: 3,  per: 15, hi: 10};
    vecs[1] = '{h: 4,  per: 20, hi: 10};
    vecs[2] = '{h: 6,  per: 30, hi: 15};
    vecs[3] = '{h: 5,  per: 25, hi: 15};
    vecs[4] = '{h: 15, per: 75, hi: 40};

    tick(3);
    chk_en = 1'b1;
    chk("reset_clockout", clockout, 0);
    chk("reset_pending", div_pending, 0);
    chk("reset_active", half_div_active, 3);
    reset = 1'b0;
    en = 1'b1;
    tick(1);
    chk("start_rise", clockout, 1);

    for (int i = 0; i < 5; i++) begin
      load(4'(vecs[i].h));
      tick(40);
      chk($sformatf("active_h%0d", vecs[i].h), half_div_active, vecs[i].h);
      measure(per, hi, ok);
      chk($sformatf("meas_ok_h%0d", vecs[i].h), ok, 1);
      chk($sformatf("period_h%0d", vecs[i].h), per, vecs[i].per);
      chk($sformatf("high_h%0d", vecs[i].h), hi, vecs[i].hi);
    end

    // Switch from 3 to 7 in the middle of a double period.
    load(4'd3);
    tick(20);
    tick(1);
    load(4'd7);
    chk("pend_after_load", div_pending, 1);
    chk("active_before_bnd", half_div_active, 3);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (half_div_active == 4'd7) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    chk("switch_seen", ok, 1);
    chk("pend_cleared", div_pending, 0);
    chk("switch_rise_on_posedge", clockout, 1);
    measure(per, hi, ok);
    chk("period_h7", per, 35);
    chk("high_h7", hi, 20);

    // Enable drop at H=5.
    load(4'd5);
    tick(30);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(20);
    en = 1'b0;
    tick(20);
    chk("en_low_hold", clockout, 0);
    en = 1'b1;
    tick(1);
    chk("en_restart_rise", clockout, 1);
    tick(12);

    // Reset in the high phase, then a clamped load.
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (clockout === 1'b1) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    chk("found_high", ok, 1);
    reset = 1'b1;
    tick(1);
    chk("reset_mid_clockout", clockout, 0);
    tick(1);
    chk("reset_mid_active", half_div_active, 3);
    chk("reset_mid_pending", div_pending, 0);
    reset = 1'b0;
    en = 1'b1;
    tick(5);
    load(4'd1);
    tick(15);
    chk("clamp_active", half_div_active, 3);
    measure(per, hi, ok);
    chk("clamp_period", per, 15);

    // Random loads, divisor wiggles and enable drops against the model.
    for (int i = 0; i < 600; i++) begin
      half_div = 4'($urandom);
      div_load = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 15) != 0);
      tick(1);
    end
    div_load = 1'b0;
    en = 1'b1;
    tick(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
